// File: rtl/vreg_pkg.sv
// Shared types and defaults for the vector register file.
package vreg_pkg;

  localparam int VECTOR = 4;
  localparam int BUS    = 4;

  typedef logic [BUS-1:0]       lane_t;
  typedef lane_t [VECTOR-1:0]   vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/vreg_read_port.sv
// One combinational read port: register select plus per-lane write bypass.
module vreg_read_port #(
  parameter int VECTOR = 4,
  parameter int BUS    = 4,
  parameter int REGS   = 8,
  parameter int ADDR   = 3
) (
  input  logic [ADDR-1:0]                        ra,
  input  logic [REGS-1:0][VECTOR-1:0][BUS-1:0]   mem,
  input  logic                                   byp_en,
  input  logic [ADDR-1:0]                        wa,
  input  logic [VECTOR-1:0][BUS-1:0]             wd,
  input  logic [VECTOR-1:0]                      wmask,
  output logic [VECTOR-1:0][BUS-1:0]             rd
);

  import vreg_pkg::*;

  // stored value, with lanes being written this cycle taken from wd instead
  always_comb begin
    rd = mem[ra];
    if (byp_en && (ra == wa)) begin
      for (int i = 0; i < VECTOR; i++) begin
        if (wmask[i]) rd[i] = wd[i];
      end
    end
  end

endmodule

// File: rtl/vreg_file_v.sv
// Vector register file: two bypassed read ports, masked write port,
// sticky per-lane carry flags and a one-register-per-cycle bulk clear.
//
// state | meaning
// IDLE  | normal operation, writes and flag updates accepted
// CLEAR | zeroing register[cnt_q] each cycle, busy high, writes dropped
module vreg_file_v #(
  parameter  int VECTOR = vreg_pkg::VECTOR,
  parameter  int BUS    = vreg_pkg::BUS,
  parameter  int REGS   = 8,
  localparam int ADDR   = $clog2(REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR-1:0]               ra1,
  input  logic [ADDR-1:0]               ra2,
  output logic [VECTOR-1:0][BUS-1:0]    rd1,
  output logic [VECTOR-1:0][BUS-1:0]    rd2,
  input  logic                          we,
  input  logic [ADDR-1:0]               wa,
  input  logic [VECTOR-1:0][BUS-1:0]    wd,
  input  logic [VECTOR-1:0]             wmask,
  input  logic [VECTOR-1:0]             carry_in,
  input  logic                          flag_we,
  input  logic                          flag_clr,
  output logic [VECTOR-1:0]             carry_sticky,
  input  logic                          clr_req,
  output logic                          busy
);

  import vreg_pkg::*;

  clr_state_t                            state_q, state_d;
  logic [ADDR-1:0]                       cnt_q;
  logic [REGS-1:0][VECTOR-1:0][BUS-1:0]  mem_q;
  logic                                  wr_en;
  logic                                  clr_start;

  assign busy      = (state_q == CLEAR);
  assign clr_start = (state_q == IDLE) && clr_req;
  // register 0 is never a write target, so its storage stays at reset zero
  assign wr_en     = we && !busy && (wa != '0);

  // clear engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // clear engine next state; a request during CLEAR is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (cnt_q == ADDR'(REGS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // clear pointer: starts at 1 since register 0 is already zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= '0;
    else if (clr_start) cnt_q <= ADDR'(1);
    else if (busy)      cnt_q <= cnt_q + ADDR'(1);
  end

  // storage: bulk clear has priority, writes dropped while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < VECTOR; i++) begin
        if (wmask[i]) mem_q[wa][i] <= wd[i];
      end
    end
  end

  // sticky carry: zeroed on clear entry, frozen while busy, clear beats set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_sticky <= '0;
    end else if (clr_start) begin
      carry_sticky <= '0;
    end else if (!busy) begin
      if (flag_clr)     carry_sticky <= '0;
      else if (flag_we) carry_sticky <= carry_sticky | (carry_in & wmask);
    end
  end

  vreg_read_port #(
    .VECTOR (VECTOR),
    .BUS    (BUS),
    .REGS   (REGS),
    .ADDR   (ADDR)
  ) u_rp1 (
    .ra     (ra1),
    .mem    (mem_q),
    .byp_en (wr_en),
    .wa     (wa),
    .wd     (wd),
    .wmask  (wmask),
    .rd     (rd1)
  );

  vreg_read_port #(
    .VECTOR (VECTOR),
    .BUS    (BUS),
    .REGS   (REGS),
    .ADDR   (ADDR)
  ) u_rp2 (
    .ra     (ra2),
    .mem    (mem_q),
    .byp_en (wr_en),
    .wa     (wa),
    .wd     (wd),
    .wmask  (wmask),
    .rd     (rd2)
  );

endmodule

// File: tb/tb_vreg_file_v.sv
// Self-checking bench for vreg_file_v with an expectation queue.
module tb_vreg_file_v;

  localparam int V = 4;
  localparam int B = 4;
  localparam int R = 8;
  localparam int A = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [A-1:0]       ra1, ra2, wa;
  logic [V-1:0][B-1:0] rd1, rd2, wd;
  logic               we;
  logic [V-1:0]       wmask, carry_in, carry_sticky;
  logic               flag_we, flag_clr, clr_req, busy;

  always #5 clk = ~clk;

  vreg_file_v #(.VECTOR(V), .BUS(B), .REGS(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .wmask        (wmask),
    .carry_in     (carry_in),
    .flag_we      (flag_we),
    .flag_clr     (flag_clr),
    .carry_sticky (carry_sticky),
    .clr_req      (clr_req),
    .busy         (busy)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_STK = 2;
  localparam int S_BSY = 3;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem_m [R];
  logic [3:0]  stk_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      S_RD1:   return 32'(rd1);
      S_RD2:   return 32'(rd2);
      S_STK:   return 32'(carry_sticky);
      default: return 32'(busy);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [3:0] m);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*4 +: 4] = nw[i*4 +: 4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; wmask = '0;
    carry_in = '0; flag_we = 1'b0; flag_clr = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic [3:0] m);
    we = 1'b1; wa = a; wd = d; wmask = m;
    tick();
    if (a != 0) mem_m[a] = merge(mem_m[a], d, m);
    we = 1'b0; wmask = '0;
  endtask

  task automatic flag_step(input logic [3:0] cin, input logic [3:0] m,
                           input logic fwe, input logic fclr, input string tag);
    carry_in = cin; wmask = m; flag_we = fwe; flag_clr = fclr;
    tick();
    if (fclr) stk_m = 4'b0000;
    else if (fwe) stk_m = stk_m | (cin & m);
    flag_we = 1'b0; flag_clr = 1'b0; carry_in = '0; wmask = '0;
    expect_val(tag, S_STK, 32'(stk_m));
    drain();
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < R; a++) begin
      ra1 = 3'(a); ra2 = 3'(a);
      expect_val({tag, "_rd1"}, S_RD1, 32'(mem_m[a]));
      expect_val({tag, "_rd2"}, S_RD2, 32'(mem_m[a]));
      drain();
    end
  endtask

  task automatic fill_regs();
    for (int a = 1; a < R; a++) do_write(3'(a), 16'(a * 32'h1111), 4'hF);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0;
    idle_inputs();
    for (int a = 0; a < R; a++) mem_m[a] = '0;
    stk_m = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    read_all("reset");
    expect_val("reset_sticky", S_STK, 32'h0);
    expect_val("reset_busy", S_BSY, 32'h0);
    drain();

    // full write then masked partial write
    do_write(3'd3, 16'hA5F1, 4'b1111);
    ra1 = 3'd3;
    expect_val("wr_full", S_RD1, 32'h0000_A5F1);
    drain();
    do_write(3'd3, 16'h0000, 4'b0101);
    expect_val("wr_mask", S_RD1, 32'h0000_A0F0);
    drain();

    // same-cycle bypass, both ports
    do_write(3'd5, 16'h7777, 4'hF);
    we = 1'b1; wa = 3'd5; wd = 16'h2222; wmask = 4'b0011;
    ra1 = 3'd5; ra2 = 3'd5;
    expect_val("byp_rd2", S_RD2, 32'h0000_7722);
    expect_val("byp_rd1", S_RD1, 32'h0000_7722);
    drain();
    tick();
    mem_m[5] = merge(mem_m[5], 16'h2222, 4'b0011);
    we = 1'b0; wmask = '0;
    expect_val("byp_commit", S_RD2, 32'(mem_m[5]));
    drain();

    // register 0 ignores writes and bypass
    we = 1'b1; wa = 3'd0; wd = 16'hFFFF; wmask = 4'hF; ra1 = 3'd0;
    expect_val("r0_byp", S_RD1, 32'h0);
    drain();
    tick();
    we = 1'b0; wmask = '0;
    expect_val("r0_after", S_RD1, 32'h0);
    drain();

    // sticky carry flags
    flag_step(4'b0001, 4'b1111, 1'b1, 1'b0, "stk_set0");
    flag_step(4'b1000, 4'b1111, 1'b1, 1'b0, "stk_set3");
    flag_step(4'b0100, 4'b0011, 1'b1, 1'b0, "stk_masked");
    flag_step(4'b1111, 4'b1111, 1'b1, 1'b1, "stk_clr_wins");
    flag_step(4'b0110, 4'b1111, 1'b1, 1'b0, "stk_pre_clear");

    // bulk clear
    fill_regs();
    flag_we = 1'b1; carry_in = 4'hF; wmask = 4'hF;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0; flag_we = 1'b0; carry_in = '0; wmask = '0;
    stk_m = 4'b0000;
    expect_val("clr_entry_busy", S_BSY, 32'h1);
    expect_val("clr_entry_sticky", S_STK, 32'(stk_m));
    drain();
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 1) begin
        ra1 = 3'd7;
        expect_val("clr_old_r7", S_RD1, 32'(mem_m[7]));
        drain();
      end
      if (n == 3) begin
        clr_req = 1'b1; flag_we = 1'b1; carry_in = 4'hF; wmask = 4'hF;
        ra2 = 3'd1;
        expect_val("clr_done_r1", S_RD2, 32'h0);
        drain();
      end
      if (n == 4) begin
        clr_req = 1'b0; flag_we = 1'b0; carry_in = '0;
        we = 1'b1; wa = 3'd2; wd = 16'hFFFF; wmask = 4'hF;
        ra2 = 3'd2;
        expect_val("clr_no_byp", S_RD2, 32'h0);
        drain();
      end
      if (n == 5) begin
        we = 1'b0; wmask = '0;
        ra2 = 3'd2;
        expect_val("clr_we_dropped", S_RD2, 32'h0);
        drain();
      end
      tick();
    end
    idle_inputs();
    check("clr_busy_cycles", 32'(n), 32'd7);
    for (int a = 0; a < R; a++) mem_m[a] = '0;
    read_all("clr_after");
    expect_val("clr_sticky_frozen", S_STK, 32'h0);
    expect_val("clr_idle", S_BSY, 32'h0);
    drain();

    // asynchronous reset in the middle of a clear
    fill_regs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    expect_val("mid_busy_pre", S_BSY, 32'h1);
    drain();
    rst_n = 1'b0;
    for (int a = 0; a < R; a++) mem_m[a] = '0;
    expect_val("mid_busy_async", S_BSY, 32'h0);
    drain();
    read_all("mid_reset");
    tick();
    rst_n = 1'b1;
    do_write(3'd1, 16'h1234, 4'hF);
    do_write(3'd2, 16'h5678, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    ra1 = 3'd1; ra2 = 3'd2;
    expect_val("restart_r1", S_RD1, 32'h0);
    expect_val("restart_r2", S_RD2, 32'h0000_5678);
    drain();
    n = 1;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("restart_busy_cycles", 32'(n), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vreg_file_v.md
Name: vreg_file_v

Overview:
- Vector register file feeding the vector ALU operand ports (a, b) and accepting its results and per-lane carry-out at writeback.
- Provides 2 combinational read ports, 1 synchronous write port with per-lane write mask, write-to-read bypass, and a sticky per-lane carry flag register.
- Includes a sequential bulk-clear engine: one register zeroed per cycle, busy-flagged, used at context switch.

Parameters:
- VECTOR, 4, lanes per vector register.
- BUS, 4, bits per lane.
- REGS, 8, number of vector registers; must be a power of 2, at least 2.
- ADDR, $clog2(REGS), register address width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra1  in  ADDR  read address, port 1 (drives ALU a).
- ra2  in  ADDR  read address, port 2 (drives ALU b).
- rd1  out  [VECTOR][BUS]  read data, port 1.
- rd2  out  [VECTOR][BUS]  read data, port 2.
- we  in  1  write enable.
- wa  in  ADDR  write address.
- wd  in  [VECTOR][BUS]  write data (ALU result).
- wmask  in  VECTOR  per-lane write enable; bit i gates lane i.
- carry_in  in  VECTOR  ALU carry_out for the instruction being written.
- flag_we  in  1  OR carry_in into the sticky flags.
- flag_clr  in  1  clear the sticky flags.
- carry_sticky  out  VECTOR  registered sticky carry per lane.
- clr_req  in  1  start a bulk clear (pulse or level).
- busy  out  1  bulk clear in progress.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, carry_sticky 0, FSM in IDLE, busy 0, clear counter 0.
- Register 0 is hardwired zero. Reads of it return 0. Writes to it are ignored, including bypass.
- Read: rd1/rd2 are combinational from ra1/ra2, so there is zero-cycle latency.
- Write: on the rising clk edge, when we=1, busy=0 and wa!=0, each lane i with wmask[i]=1 is updated to wd[i]. Unmasked lanes keep their old value.
- Bypass: when we=1, busy=0, wa!=0 and ra==wa, each rdX lane i returns wd[i] if wmask[i]=1, else the stored lane. Both ports bypass independently.
- Sticky flags, on clk:
  - If flag_clr=1, carry_sticky becomes 0. Clear wins over set in the same cycle.
  - Else if flag_we=1, carry_sticky becomes carry_sticky | (carry_in & wmask).
  - flag_we and flag_clr are ignored while busy=1.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1. The counter loads 1 and busy goes high in the next cycle.
  - In CLEAR, each cycle writes register[counter] to all zeros, and the counter increments.
  - When counter==REGS-1 is cleared, go to IDLE and drop busy. Total busy time is REGS-1 cycles.
  - clr_req asserted during CLEAR is ignored, with no restart.
  - carry_sticky is zeroed on the CLEAR entry edge.
- While busy=1:
  - we is ignored and writes are dropped; the upstream stage must stall on busy.
  - Reads remain valid. A register already cleared reads 0; an uncleared one reads its old value.
- Asynchronous reset mid-CLEAR aborts immediately to the reset state.
- There is no arithmetic on data. Lane widths pass through unchanged, with no truncation or extension.

Decomposition:
- Package vreg_pkg holds:
  - VECTOR and BUS defaults.
  - typedef lane_t = logic [BUS-1:0].
  - typedef vec_t = lane_t [VECTOR-1:0].
  - enum clr_state_t {IDLE, CLEAR}.
- One natural sub-module, vreg_read_port: a read mux plus the masked bypass merge, instantiated twice.
- The FSM, storage array and sticky flags stay in the top module.

Test Plan:
- Reset then read all addresses -> rd1=rd2=0 for ra 0..7; carry_sticky=4'b0000; busy=0.
- Write wa=3, wd={4'hA,4'h5,4'hF,4'h1}, wmask=4'b1111. Next cycle ra1=3 -> rd1={A,5,F,1}. Then write wa=3, wd=all 4'h0, wmask=4'b0101 -> lanes 0 and 2 become 0, lanes 1 and 3 are unchanged.
- Same-cycle bypass: stored r5=all 4'h7; we=1, wa=5, wd=all 4'h2, wmask=4'b0011, ra2=5 -> rd2 lanes 0,1 =2 and lanes 2,3 =7 in the same cycle. Write to wa=0 -> ra1=0 still reads 0.
- Sticky flags:
  - carry_in=4'b0001, flag_we=1, wmask=4'b1111 -> 0001.
  - Then carry_in=4'b1000 -> 1001.
  - Then carry_in=4'b0100 with wmask=4'b0011 -> stays 1001.
  - Then flag_clr=1 and flag_we=1 together -> 0000.
- Bulk clear:
  - Fill r1..r7 nonzero, pulse clr_req -> busy high for exactly 7 cycles; then all reads are 0.
  - A we during busy to r2 leaves r2=0.
  - A clr_req during busy has no extension.
- Reset mid-clear: assert rst_n=0 after 3 CLEAR cycles -> busy=0 immediately, all registers 0, FSM IDLE. Next clr_req restarts from r1.
